// File: rtl/rename_pkg.sv
// Shared types and constants for the rename-stage free list.
// Contents: register-file geometry, free-list pointer widths, physical
// register ID type, free-list FSM state encoding and a full-test helper.
package rename_pkg;

  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int FL_DEPTH  = NUM_PREGS - NUM_AREGS;
  localparam int PREG_W    = $clog2(NUM_PREGS);
  localparam int IDX_W     = $clog2(FL_DEPTH);
  localparam int PTR_W     = IDX_W + 1;
  localparam int CNT_W     = $clog2(FL_DEPTH) + 1;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PTR_W-1:0]  ptr_t;

  typedef enum logic [1:0] {
    FL_INIT    = 2'd0,
    FL_RUN     = 2'd1,
    FL_RECOVER = 2'd2
  } fl_state_e;

  // Full: same slot index but the wrap bits disagree.
  function automatic logic ptr_full(input ptr_t tail, input ptr_t head);
    return (tail[IDX_W-1:0] == head[IDX_W-1:0]) && (tail[IDX_W] != head[IDX_W]);
  endfunction

endpackage

// File: rtl/free_list_ctrl_if.sv
// Rename/commit-side bundle for the free-list controller.
// master: rename + commit logic (drives requests, releases, flush).
// slave : the free-list controller (returns grant, preg ID and status).
interface free_list_ctrl_if;
  import rename_pkg::*;

  logic              alloc_req;
  logic              alloc_grant;
  preg_t             alloc_preg;
  logic              rel_valid;
  preg_t             rel_preg;
  logic              commit_alloc;
  logic              flush;
  logic              ready;
  logic [CNT_W-1:0]  free_count;
  logic              err;

  modport master (
    output alloc_req, rel_valid, rel_preg, commit_alloc, flush,
    input  alloc_grant, alloc_preg, ready, free_count, err
  );

  modport slave (
    input  alloc_req, rel_valid, rel_preg, commit_alloc, flush,
    output alloc_grant, alloc_preg, ready, free_count, err
  );

endinterface

// File: rtl/free_list_ram.sv
// Free-list storage: FL_DEPTH x PREG_W, one asynchronous read port and one
// synchronous write port. Contents are deliberately not reset; the
// controller refills every entry during its INIT phase.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module free_list_ram
  import rename_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  preg_t            wdata,
  input  logic [IDX_W-1:0] raddr,
  output preg_t            rdata
);

  preg_t mem_r [FL_DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/free_list_ctrl.sv
// R10000-style physical register free list.
// Hands out one free preg per cycle at rename, takes superseded pregs back
// at commit, and on flush rewinds the speculative head to the committed head.
// Ports: clk, rst (async, active-high), bus (free_list_ctrl_if.slave):
//   alloc_req/alloc_grant/alloc_preg, rel_valid/rel_preg, commit_alloc,
//   flush, ready, free_count, err.
module free_list_ctrl
  import rename_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  free_list_ctrl_if.slave  bus
);

  localparam ptr_t             PTR_ONE  = ptr_t'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FL_DEPTH - 1);

  fl_state_e        state_r, state_nxt_s;
  ptr_t             head_r, head_nxt_s;
  ptr_t             commit_head_r, commit_head_nxt_s;
  ptr_t             tail_r, tail_nxt_s;
  logic [IDX_W-1:0] init_cnt_r, init_cnt_nxt_s;
  logic             err_r, err_nxt_s;

  logic             grant_s;
  logic             we_s;
  logic [IDX_W-1:0] waddr_s;
  preg_t            wdata_s;
  preg_t            rdata_s;
  ptr_t             free_count_s;

  free_list_ram u_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (wdata_s),
    .raddr (head_r[IDX_W-1:0]),
    .rdata (rdata_s)
  );

  assign free_count_s = tail_r - head_r;

  // Next-state, pointer and write-port logic for the INIT/RUN/RECOVER FSM.
  always_comb begin
    state_nxt_s       = state_r;
    head_nxt_s        = head_r;
    commit_head_nxt_s = commit_head_r;
    tail_nxt_s        = tail_r;
    init_cnt_nxt_s    = init_cnt_r;
    err_nxt_s         = err_r;
    grant_s           = 1'b0;
    we_s              = 1'b0;
    waddr_s           = tail_r[IDX_W-1:0];
    wdata_s           = bus.rel_preg;

    case (state_r)
      FL_INIT: begin
        // Seed the list with pregs NUM_AREGS..NUM_PREGS-1.
        we_s           = 1'b1;
        waddr_s        = init_cnt_r;
        wdata_s        = preg_t'(NUM_AREGS) + preg_t'(init_cnt_r);
        init_cnt_nxt_s = init_cnt_r + IDX_ONE;
        tail_nxt_s     = tail_r + PTR_ONE;
        if (init_cnt_r == IDX_LAST) begin
          state_nxt_s = FL_RUN;
        end else begin
          state_nxt_s = FL_INIT;
        end
      end

      FL_RUN, FL_RECOVER: begin
        grant_s = (state_r == FL_RUN) && bus.alloc_req &&
                  (free_count_s != ptr_t'(0)) && !bus.flush;

        // Releases are older than any flush, so they are always honoured.
        if (bus.rel_valid) begin
          if (ptr_full(tail_r, head_r)) begin
            err_nxt_s = 1'b1;
          end else begin
            we_s       = 1'b1;
            tail_nxt_s = tail_r + PTR_ONE;
          end
        end else begin
          tail_nxt_s = tail_r;
        end

        if (bus.commit_alloc) begin
          if (commit_head_r == head_r) begin
            err_nxt_s = 1'b1;
          end else begin
            commit_head_nxt_s = commit_head_r + PTR_ONE;
          end
        end else begin
          commit_head_nxt_s = commit_head_r;
        end

        // Flush rewinds to the committed head including this cycle's commit.
        if ((state_r == FL_RUN) && bus.flush) begin
          head_nxt_s  = commit_head_nxt_s;
          state_nxt_s = FL_RECOVER;
        end else if (grant_s) begin
          head_nxt_s  = head_r + PTR_ONE;
          state_nxt_s = FL_RUN;
        end else begin
          head_nxt_s  = head_r;
          state_nxt_s = FL_RUN;
        end
      end

      default: begin
        state_nxt_s = FL_INIT;
      end
    endcase
  end

  // State and pointer registers; rst returns straight to INIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= FL_INIT;
      head_r        <= ptr_t'(0);
      commit_head_r <= ptr_t'(0);
      tail_r        <= ptr_t'(0);
      init_cnt_r    <= IDX_W'(0);
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      head_r        <= head_nxt_s;
      commit_head_r <= commit_head_nxt_s;
      tail_r        <= tail_nxt_s;
      init_cnt_r    <= init_cnt_nxt_s;
      err_r         <= err_nxt_s;
    end
  end

  assign bus.alloc_grant = grant_s;
  assign bus.alloc_preg  = grant_s ? rdata_s : {PREG_W{1'b0}};
  assign bus.ready       = (state_r == FL_RUN) || (state_r == FL_RECOVER);
  assign bus.free_count  = free_count_s;
  assign bus.err         = err_r;

endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed self-checking bench for free_list_ctrl.
// Covers reset, initial fill, allocation sweep, empty+release, flush with
// same-cycle traffic, mid-run reset, release-into-full error and rewind.
module tb_free_list_ctrl;
  import rename_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  free_list_ctrl_if bus ();

  free_list_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Run-time bound.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    rst               = 1'b1;
    bus.alloc_req     = 1'b0;
    bus.rel_valid     = 1'b0;
    bus.rel_preg      = '0;
    bus.commit_alloc  = 1'b0;
    bus.flush         = 1'b0;
    #1;
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_grant", 32'(bus.alloc_grant), 32'd0);
    check("rst_preg", 32'(bus.alloc_preg), 32'd0);
    check("rst_free", 32'(bus.free_count), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);

    // Initial fill takes exactly 32 cycles.
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 31; i++) step();
    check("init_ready_early", 32'(bus.ready), 32'd0);
    check("init_free_31", 32'(bus.free_count), 32'd31);
    step();
    check("init_ready", 32'(bus.ready), 32'd1);
    check("init_free_32", 32'(bus.free_count), 32'd32);

    // Back-to-back allocation drains 32..63 in order.
    bus.alloc_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      check("sweep_grant", 32'(bus.alloc_grant), 32'd1);
      check("sweep_preg", 32'(bus.alloc_preg), 32'(32 + i));
      step();
    end
    #1;
    check("empty_grant", 32'(bus.alloc_grant), 32'd0);
    check("empty_free", 32'(bus.free_count), 32'd0);

    // Empty list: release is not bypassed to the same-cycle allocation.
    bus.rel_valid = 1'b1;
    bus.rel_preg  = 6'd5;
    #1;
    check("emptyrel_nogrant", 32'(bus.alloc_grant), 32'd0);
    step();
    bus.rel_valid = 1'b0;
    #1;
    check("emptyrel_grant", 32'(bus.alloc_grant), 32'd1);
    check("emptyrel_preg", 32'(bus.alloc_preg), 32'd5);
    step();
    bus.alloc_req = 1'b0;

    // Two commits (commit_head=2), then flush+alloc+release+commit together.
    bus.commit_alloc = 1'b1;
    step();
    step();
    bus.flush     = 1'b1;
    bus.alloc_req = 1'b1;
    bus.rel_valid = 1'b1;
    bus.rel_preg  = 6'd40;
    #1;
    check("flush_nogrant", 32'(bus.alloc_grant), 32'd0);
    step();
    bus.flush        = 1'b0;
    bus.rel_valid    = 1'b0;
    bus.commit_alloc = 1'b0;
    #1;
    check("recover_nogrant", 32'(bus.alloc_grant), 32'd0);
    check("flush_free", 32'(bus.free_count), 32'd31);
    step();
    #1;
    check("post_flush_grant", 32'(bus.alloc_grant), 32'd1);
    check("post_flush_preg", 32'(bus.alloc_preg), 32'd35);
    step();

    // Drain to free_count=10, then reset asynchronously mid-cycle.
    for (int i = 0; i < 20; i++) step();
    bus.alloc_req = 1'b0;
    #1;
    check("pre_rst_free", 32'(bus.free_count), 32'd10);
    bus.alloc_req = 1'b1;
    #1;
    check("pre_rst_grant", 32'(bus.alloc_grant), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_grant", 32'(bus.alloc_grant), 32'd0);
    check("midrst_free", 32'(bus.free_count), 32'd0);
    check("midrst_ready", 32'(bus.ready), 32'd0);
    bus.alloc_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) step();
    check("reinit_ready", 32'(bus.ready), 32'd1);
    check("reinit_free", 32'(bus.free_count), 32'd32);
    check("reinit_err", 32'(bus.err), 32'd0);

    // Release into a full list: suppressed, sticky error.
    bus.rel_valid = 1'b1;
    bus.rel_preg  = 6'd7;
    step();
    bus.rel_valid = 1'b0;
    #1;
    check("full_err", 32'(bus.err), 32'd1);
    check("full_free", 32'(bus.free_count), 32'd32);
    step();
    step();
    step();
    check("err_sticky", 32'(bus.err), 32'd1);

    // Allocate 3, commit 1, flush: rewind to commit_head=1.
    bus.alloc_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("alloc3_preg", 32'(bus.alloc_preg), 32'(32 + i));
      step();
    end
    bus.alloc_req    = 1'b0;
    bus.commit_alloc = 1'b1;
    step();
    bus.commit_alloc = 1'b0;
    bus.flush        = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.alloc_req = 1'b1;
    #1;
    check("rewind_recover_nogrant", 32'(bus.alloc_grant), 32'd0);
    step();
    #1;
    check("rewind_free", 32'(bus.free_count), 32'd31);
    check("rewind_grant", 32'(bus.alloc_grant), 32'd1);
    check("rewind_preg", 32'(bus.alloc_preg), 32'd33);
    step();
    bus.alloc_req = 1'b0;
    check("err_still_set", 32'(bus.err), 32'd1);

    // Only reset clears the error.
    rst = 1'b1;
    #1;
    check("err_cleared", 32'(bus.err), 32'd0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/free_list_ctrl.md
Name: free_list_ctrl

Overview:
- Physical-register free-list controller for the out-of-order rename stage.
- Hands out free physical register IDs to the register map table at rename, one per cycle.
- Takes back superseded physical registers from the active list at commit.
- On a pipeline flush, reclaims every speculatively allocated register by rewinding the speculative head to the committed head. This is the R10000-style free list that currently lives as an ad hoc array inside the map table.

Parameters:
- NUM_PREGS, 64, number of physical registers.
- NUM_AREGS, 32, number of architectural registers, always mapped.
- FL_DEPTH, NUM_PREGS-NUM_AREGS (32), free-list capacity.
- PREG_W, $clog2(NUM_PREGS) (6), physical register ID width.
- CNT_W, $clog2(FL_DEPTH)+1 (6), occupancy counter width.

Ports:
- clk  in  1  clock, posedge.
- rst  in  1  reset, asynchronous, active-high.
- alloc_req  in  1  rename stage wants one physical register this cycle.
- alloc_grant  out  1  allocation accepted this cycle.
- alloc_preg  out  PREG_W  allocated register ID; valid only when alloc_grant=1.
- rel_valid  in  1  commit frees one register.
- rel_preg  in  PREG_W  ID being freed.
- commit_alloc  in  1  the committing instruction had allocated a register; advances the committed head.
- flush  in  1  squash all uncommitted allocations.
- ready  out  1  initialisation complete.
- free_count  out  CNT_W  speculative free entries (tail - head).
- err  out  1  sticky error: release into a full list, or commit_alloc with committed head == head.

Behaviour:
- Reset: one clock, clk; reset rst is asynchronous and active-high.
  - While rst=1: state=INIT, head=commit_head=tail=0, init_cnt=0, ready=0, alloc_grant=0, alloc_preg=0, free_count=0, err=0.
- Storage: FL_DEPTH x PREG_W array, not reset.
- Pointers: head, commit_head and tail are $clog2(FL_DEPTH)+1 bits wide. The MSB is a wrap bit.
  - Empty when head==tail.
  - Full when the indices are equal and the wrap bits differ.
  - free_count = tail - head, modulo 2^(ptr width).
- FSM INIT:
  - Each cycle writes mem[init_cnt] = NUM_AREGS + init_cnt, then increments init_cnt and tail.
  - After FL_DEPTH cycles (32), goes to RUN with tail = FL_DEPTH (wrap bit set) and free_count = 32.
  - Architectural regs 0..NUM_AREGS-1 are implicitly mapped and never in the initial list.
  - rel_valid, commit_alloc and flush are ignored in INIT. alloc_grant=0.
- FSM RUN:
  - alloc_grant = alloc_req & (free_count!=0) & ~flush. This is combinational, zero latency.
  - alloc_preg = mem[head[idx]], combinational. It is driven 0 when not granted.
  - On grant, head increments at the clock edge.
  - rel_valid writes mem[tail[idx]] = rel_preg and increments tail. The entry is visible to allocation the next cycle; there is no same-cycle bypass.
  - commit_alloc increments commit_head.
- FSM flush (in RUN):
  - Next head = commit_head plus commit_alloc (same-cycle commit counted first).
  - State goes to RECOVER for exactly 1 cycle with alloc_grant=0.
  - State then returns to RUN.
  - Release and commit are still accepted in RECOVER.
- Simultaneous events:
  - Alloc + release in the same cycle: both apply and free_count is unchanged.
  - Alloc with free_count==0 plus release in the same cycle: no grant. tail++.
  - Flush + alloc_req: flush wins, no grant.
  - Flush + release: the release is accepted, because it is older than the flush.
- Error cases:
  - Release when full: write suppressed, tail held, err set.
  - commit_alloc when commit_head==head: commit_head held, err set.
  - err clears only on rst.
- Reset asserted mid-operation: immediate return to INIT. The list is refilled from scratch and any in-flight grant is lost.
- Wrap-around: pointer indices wrap modulo FL_DEPTH with the wrap bit toggling. No special case.

Decomposition:
- Package rename_pkg holds:
  - constants NUM_PREGS, NUM_AREGS, FL_DEPTH, PREG_W;
  - typedef logic [PREG_W-1:0] preg_t;
  - enum fl_state_e {FL_INIT, FL_RUN, FL_RECOVER}.
- Sub-module free_list_ram: 1 asynchronous read port, 1 synchronous write port, FL_DEPTH x PREG_W. It isolates storage for a later move to memory blocks.
- The pointers and FSM stay in free_list_ctrl.

Test Plan:
1. Reset, then 32 idle cycles -> ready=1 at cycle 32, free_count=32. The first alloc returns preg 32, then 33. Back-to-back allocs produce 32..63 in order and grant drops when free_count=0.
2. Allocate 3 (32,33,34), commit_alloc once, flush -> head rewinds to commit_head=1. The RECOVER cycle gives no grant. The next alloc returns 33 and free_count=31.
3. Empty list, alloc_req=1 with rel_valid=1, rel_preg=5 -> no grant this cycle. The next cycle grants preg 5.
4. Full list (32 free), rel_valid with preg 7 -> err=1, free_count stays 32, err persists until rst.
5. Same cycle flush, alloc_req, rel_valid (preg 40) and commit_alloc -> no grant, tail advances. Head = old commit_head+1, and free_count reflects both.
6. Assert rst during RUN with free_count=10 -> outputs go to 0 immediately. After rst is released, the list re-initialises to 32..63 over 32 cycles.
